// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Each cycle it picks the next instruction address from exception, redirect,
// return, stall-hold or sequential increment, in that priority order.
// Optional feature macro: PC_GEN_RAS_EN builds a circular return-address
// stack that predicts return targets; without it returns always use the
// architectural ret_target and call_valid has no effect.
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h8000_0180,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [WIDTH-1:0]               redirect_target,
  input  logic                           call_valid,
  input  logic                           ret_valid,
  input  logic [WIDTH-1:0]               ret_target,
  input  logic                           exc_valid,
  output logic [WIDTH-1:0]               ia,
  output logic                           ia_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_hit
);

  localparam int               CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  // INC is a power of two, so INC-1 covers exactly the sub-alignment bits.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(INC_W - WIDTH'(1));

  // Clear the sub-instruction offset bits of a target address.
  function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  logic [WIDTH-1:0] ia_r;
  logic             ia_valid_r;
  logic [WIDTH-1:0] link_s;      // sequential successor, also the call link
  logic [WIDTH-1:0] ret_pred_s;  // address a return resolves to
  logic [WIDTH-1:0] next_ia_s;

  // Natural wrap of the adder gives the modulo-2^WIDTH increment.
  assign link_s = ia_r + INC_W;

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]    ras_ptr_r;       // next slot to write
  logic [PW-1:0]    ras_top_idx_s;   // most recently pushed slot
  logic [CW-1:0]    ras_count_r;
  logic             ras_hit_r;
  logic             ras_nonempty_s;
  logic             pop_s;
  logic             push_s;

  assign ras_nonempty_s = (ras_count_r != {CW{1'b0}});
  assign ras_top_idx_s  = ras_ptr_r - PW'(1);
  // A return pops whenever the stack holds something, even if a redirect wins.
  assign pop_s  = ia_valid_r & ret_valid & ~exc_valid & ras_nonempty_s;
  // A call held by a stall (with no redirect) will be re-presented, so skip it.
  assign push_s = ia_valid_r & call_valid & ~exc_valid & ~(stall & ~redirect_valid);
  assign ret_pred_s = ras_nonempty_s ? ras_mem_r[ras_top_idx_s] : align_addr(ret_target);

  // Stack pointer, occupancy and hit pulse; exception flushes the stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr_r   <= {PW{1'b0}};
      ras_count_r <= {CW{1'b0}};
      ras_hit_r   <= 1'b0;
    end else begin
      ras_hit_r <= pop_s & ~redirect_valid;
      if (ia_valid_r && exc_valid) begin
        ras_ptr_r   <= {PW{1'b0}};
        ras_count_r <= {CW{1'b0}};
      end else if (pop_s && push_s) begin
        // Top entry is replaced in place; depth is unchanged.
        ras_ptr_r   <= ras_ptr_r;
        ras_count_r <= ras_count_r;
      end else if (pop_s) begin
        ras_ptr_r   <= ras_top_idx_s;
        ras_count_r <= ras_count_r - CW'(1);
      end else if (push_s) begin
        // When full the write slot is the oldest entry, which gets overwritten.
        ras_ptr_r <= ras_ptr_r + PW'(1);
        if (ras_count_r != CW'(RAS_DEPTH)) begin
          ras_count_r <= ras_count_r + CW'(1);
        end else begin
          ras_count_r <= ras_count_r;
        end
      end else begin
        ras_ptr_r   <= ras_ptr_r;
        ras_count_r <= ras_count_r;
      end
    end
  end

  // Stack storage; entries carry no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      if (pop_s) begin
        ras_mem_r[ras_top_idx_s] <= link_s;
      end else begin
        ras_mem_r[ras_ptr_r] <= link_s;
      end
    end
  end

  assign ras_count = ras_count_r;
  assign ras_hit   = ras_hit_r;
`else
  logic unused_call_s;

  assign unused_call_s = call_valid;
  assign ret_pred_s    = align_addr(ret_target);
  assign ras_count     = {CW{1'b0}};
  assign ras_hit       = 1'b0;
`endif

  // Next-address selection in strict priority order.
  always_comb begin
    next_ia_s = ia_r;
    if (exc_valid) begin
      next_ia_s = EXC_VEC;
    end else if (redirect_valid) begin
      next_ia_s = align_addr(redirect_target);
    end else if (ret_valid) begin
      next_ia_s = ret_pred_s;
    end else if (stall) begin
      next_ia_s = ia_r;
    end else begin
      next_ia_s = link_s;
    end
  end

  // Address register; the first edge after reset only raises ia_valid so
  // RESET_VEC is actually fetched before any control takes effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ia_r       <= RESET_VEC;
      ia_valid_r <= 1'b0;
    end else if (!ia_valid_r) begin
      ia_r       <= ia_r;
      ia_valid_r <= 1'b1;
    end else begin
      ia_r       <= next_ia_s;
      ia_valid_r <= 1'b1;
    end
  end

  assign ia       = ia_r;
  assign ia_valid = ia_valid_r;

endmodule
